// File: rtl/ba_cmd_arbiter.sv
// Multi-bank command arbiter: picks at most one bank command per cycle with
// direction grouping, turnaround bubbles, round-robin fairness and an age override.
module ba_cmd_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int CMD_W     = 4,
  parameter int ADDR_W    = 14,
  parameter int BA_W      = 3,
  parameter int BURST_MAX = 4,
  parameter int TURN_CYC  = 2,
  parameter int AGE_TH    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          isu_fifo_full,
  input  logic [NUM_BANKS-1:0]          ba_req,
  input  logic [2*NUM_BANKS-1:0]        ba_cls,
  input  logic [CMD_W*NUM_BANKS-1:0]    ba_cmd,
  input  logic [ADDR_W*NUM_BANKS-1:0]   ba_addr,
  output logic [NUM_BANKS-1:0]          ba_grant,
  output logic [NUM_BANKS-1:0]          ba_stall,
  output logic [CMD_W+BA_W+ADDR_W-1:0]  sch_out,
  output logic                          sch_issue,
  output logic                          dbg_state_o,
  output logic                          dbg_mode_o
);
  // Handshake: ba_req[i] is valid, ba_grant[i] is ready; a command transfers in a
  // cycle where both are 1, and the bank holds cls/cmd/addr stable until then.

  typedef enum logic {ST_ARB = 1'b0, ST_TURN = 1'b1} state_e;

  localparam int BC_W = $clog2(BURST_MAX + 1);
  localparam logic [BC_W-1:0] BURST_L = BC_W'(BURST_MAX);
  localparam logic [2:0]      TURN_L  = 3'(TURN_CYC);
  localparam logic [7:0]      AGE_L   = 8'(AGE_TH);
  localparam logic [BA_W-1:0] LAST_L  = BA_W'(NUM_BANKS - 1);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;     // 1 = WRITE, 0 = READ
  logic [BA_W-1:0]     rr_q, rr_d;
  logic [BC_W-1:0]     burst_q, burst_d;
  logic [2:0]          turn_q, turn_d;
  logic [7:0]          age_q [NUM_BANKS];
  logic [7:0]          age_d [NUM_BANKS];
  logic                sch_issue_q;
  logic [CMD_W+BA_W+ADDR_W-1:0] sch_out_q;

  logic [NUM_BANKS-1:0] is_data, same_dir, opp, aged, cand, sel_oh;
  logic                 sel_valid, sel_opp, sel_data, grant_ok;
  logic [BA_W-1:0]      sel_idx;
  logic [CMD_W-1:0]     win_cmd;
  logic [ADDR_W-1:0]    win_addr;

  always_comb begin
    is_data  = '0;
    same_dir = '0;
    opp      = '0;
    aged     = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      is_data[i]  = (ba_cls[2*i +: 2] == 2'd1) || (ba_cls[2*i +: 2] == 2'd2);
      same_dir[i] = mode_q ? (ba_cls[2*i +: 2] == 2'd2) : (ba_cls[2*i +: 2] == 2'd1);
      opp[i]      = ba_req[i] && is_data[i] && !same_dir[i];
      aged[i]     = ba_req[i] && (age_q[i] >= AGE_L);
    end
    // Aged banks exclude everyone else, including same-direction traffic.
    cand = (|aged) ? aged : (ba_req & (~is_data | same_dir));
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (!sel_valid && cand[(int'(rr_q) + k) % NUM_BANKS]) begin
        sel_valid = 1'b1;
        sel_idx   = BA_W'((int'(rr_q) + k) % NUM_BANKS);
        sel_oh[(int'(rr_q) + k) % NUM_BANKS] = 1'b1;
      end
    end
    sel_opp  = |(sel_oh & opp);
    sel_data = |(sel_oh & is_data);
  end

  always_comb begin
    win_cmd  = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (sel_oh[i]) begin
        win_cmd  = ba_cmd[i*CMD_W +: CMD_W];
        win_addr = ba_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rr_d     = rr_q;
    burst_d  = burst_q;
    turn_d   = turn_q;
    grant_ok = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (!isu_fifo_full) begin
          if (|aged) begin
            if (sel_opp) begin
              state_d = ST_TURN;
              turn_d  = TURN_L;
            end else begin
              grant_ok = sel_valid;
            end
          end else if ((|opp) && (!sel_valid || burst_q == BURST_L)) begin
            // A full burst lets the switch beat a waiting CTRL request.
            state_d = ST_TURN;
            turn_d  = TURN_L;
          end else begin
            grant_ok = sel_valid;
          end
          if (grant_ok) begin
            rr_d = (sel_idx == LAST_L) ? '0 : sel_idx + 1'b1;
            if (sel_data && burst_q != BURST_L) burst_d = burst_q + 1'b1;
          end
        end
      end
      ST_TURN: begin
        if (turn_q <= 3'd1) begin
          state_d = ST_ARB;
          mode_d  = ~mode_q;
          burst_d = '0;
          turn_d  = '0;
        end else begin
          turn_d = turn_q - 3'd1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign ba_grant = (rst_n && grant_ok) ? sel_oh : '0;
  assign ba_stall = ba_req & ~ba_grant;

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!ba_req[i] || ba_grant[i]) age_d[i] = 8'd0;
      else if (age_q[i] != 8'hFF)    age_d[i] = age_q[i] + 8'd1;
      else                           age_d[i] = age_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      mode_q      <= 1'b1;
      rr_q        <= '0;
      burst_q     <= '0;
      turn_q      <= '0;
      sch_issue_q <= 1'b0;
      sch_out_q   <= '0;
      for (int i = 0; i < NUM_BANKS; i++) age_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rr_q        <= rr_d;
      burst_q     <= burst_d;
      turn_q      <= turn_d;
      sch_issue_q <= |ba_grant;
      if (|ba_grant) sch_out_q <= {win_cmd, sel_idx, win_addr};
      for (int i = 0; i < NUM_BANKS; i++) age_q[i] <= age_d[i];
    end
  end

  assign sch_out     = sch_out_q;
  assign sch_issue   = sch_issue_q;
  assign dbg_state_o = state_q;
  assign dbg_mode_o  = mode_q;

endmodule

// File: tb/tb_ba_cmd_arbiter.sv
// Directed bench for ba_cmd_arbiter: per-cycle expected grants, and an issue-word
// queue filled at each expected grant and drained when the registered push appears.
module tb_ba_cmd_arbiter;
  localparam int OW = 21;
  localparam logic ARB = 1'b0, TURN = 1'b1, WR = 1'b1, RD = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, full;
  logic [3:0]      req;
  logic [1:0]      cls_v  [4];
  logic [3:0]      cmd_v  [4];
  logic [13:0]     addr_v [4];
  logic [7:0]      cls_bus;
  logic [15:0]     cmd_bus;
  logic [55:0]     addr_bus;
  logic [3:0]      ba_grant, ba_stall;
  logic [OW-1:0]   sch_out;
  logic            sch_issue, dbg_state, dbg_mode;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cls_bus[2*i +: 2]   = cls_v[i];
      cmd_bus[4*i +: 4]   = cmd_v[i];
      addr_bus[14*i +: 14] = addr_v[i];
    end
  end

  ba_cmd_arbiter dut (
    .clk(clk), .rst_n(rst_n), .isu_fifo_full(full),
    .ba_req(req), .ba_cls(cls_bus), .ba_cmd(cmd_bus), .ba_addr(addr_bus),
    .ba_grant(ba_grant), .ba_stall(ba_stall),
    .sch_out(sch_out), .sch_issue(sch_issue),
    .dbg_state_o(dbg_state), .dbg_mode_o(dbg_mode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bank(input int i, input logic r, input logic [1:0] c);
    req[i]   = r;
    cls_v[i] = c;
  endtask

  // One cycle: check combinational grant/stall and state, then the registered push.
  task automatic step(input string tag, input logic [3:0] eg, input logic es, input logic em);
    int g;
    g = -1;
    @(negedge clk);
    check({tag, ".grant"}, 32'(ba_grant), 32'(eg));
    check({tag, ".stall"}, 32'(ba_stall), 32'(req & ~eg));
    check({tag, ".state"}, 32'(dbg_state), 32'(es));
    check({tag, ".mode"},  32'(dbg_mode),  32'(em));
    for (int i = 0; i < 4; i++) if (eg[i]) g = i;
    if (g >= 0) exp_q.push_back({cmd_v[g], 3'(g), addr_v[g]});
    @(posedge clk);
    #1;
    check({tag, ".issue"}, 32'(sch_issue), 32'(g >= 0));
    if (g >= 0) begin
      if (exp_q.size() == 0) begin
        check({tag, ".queue"}, 32'(0), 32'(1));
      end else begin
        check({tag, ".word"}, 32'(sch_out), 32'(exp_q.pop_front()));
      end
      cmd_v[g]  = 4'($urandom_range(0, 15));
      addr_v[g] = 14'($urandom_range(0, 16383));
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    check({tag, ".rst_grant"}, 32'(ba_grant), 32'(0));
    @(posedge clk);
    #1;
    check({tag, ".rst_issue"}, 32'(sch_issue), 32'(0));
    check({tag, ".rst_out"},   32'(sch_out),   32'(0));
    check({tag, ".rst_state"}, 32'(dbg_state), 32'(ARB));
    check({tag, ".rst_mode"},  32'(dbg_mode),  32'(WR));
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    full  = 1'b0;
    req   = '0;
    for (int i = 0; i < 4; i++) begin
      cls_v[i]  = 2'd0;
      cmd_v[i]  = 4'($urandom_range(0, 15));
      addr_v[i] = 14'($urandom_range(0, 16383));
    end
    req = 4'b1111;  // requests present during reset must not be granted
    do_reset("init");

    // Round robin over CTRL requests; bank 3 uses class 3.
    set_bank(3, 1'b1, 2'd3);
    step("rr0", 4'b0001, ARB, WR);
    step("rr1", 4'b0010, ARB, WR);
    step("rr2", 4'b0100, ARB, WR);
    step("rr3", 4'b1000, ARB, WR);
    step("rr4", 4'b0001, ARB, WR);

    // Write burst then switch to read.
    req = '0;
    do_reset("wb");
    set_bank(0, 1'b1, 2'd2);
    set_bank(1, 1'b1, 2'd1);
    for (int k = 0; k < 4; k++) step("wb_w", 4'b0001, ARB, WR);
    step("wb_sw", 4'b0000, ARB, WR);
    step("wb_t0", 4'b0000, TURN, WR);
    step("wb_t1", 4'b0000, TURN, WR);
    for (int k = 0; k < 4; k++) step("wb_r", 4'b0010, ARB, RD);
    step("wb_sw2", 4'b0000, ARB, RD);

    // Back-pressure on a CTRL request.
    req = '0;
    do_reset("bp");
    set_bank(2, 1'b1, 2'd0);
    full = 1'b1;
    for (int k = 0; k < 5; k++) step("bp_full", 4'b0000, ARB, WR);
    full = 1'b0;
    step("bp_go", 4'b0100, ARB, WR);
    req[2] = 1'b0;
    step("bp_idle", 4'b0000, ARB, WR);

    // Starvation of a READ behind continuous CTRL traffic.
    do_reset("sv");
    set_bank(0, 1'b1, 2'd0);
    set_bank(1, 1'b1, 2'd0);
    set_bank(2, 1'b1, 2'd1);
    for (int k = 0; k < 16; k++) step("sv_ctrl", 4'(1 << (k % 2)), ARB, WR);
    step("sv_aged", 4'b0000, ARB, WR);
    step("sv_t0", 4'b0000, TURN, WR);
    step("sv_t1", 4'b0000, TURN, WR);
    step("sv_win", 4'b0100, ARB, RD);
    req[2] = 1'b0;
    step("sv_after", 4'b0001, ARB, RD);

    // Full burst: switch beats a pending CTRL request.
    req = '0;
    do_reset("sc4");
    set_bank(0, 1'b1, 2'd2);
    for (int k = 0; k < 4; k++) step("sc4_w", 4'b0001, ARB, WR);
    set_bank(1, 1'b1, 2'd1);
    set_bank(2, 1'b1, 2'd0);
    step("sc4_sw", 4'b0000, ARB, WR);
    step("sc4_t0", 4'b0000, TURN, WR);
    step("sc4_t1", 4'b0000, TURN, WR);
    step("sc4_rd", 4'b0010, ARB, RD);
    req[1] = 1'b0;
    step("sc4_ctrl", 4'b0100, ARB, RD);

    // Partial burst: CTRL request is served before the switch.
    req = '0;
    do_reset("sc2");
    set_bank(0, 1'b1, 2'd2);
    step("sc2_w0", 4'b0001, ARB, WR);
    step("sc2_w1", 4'b0001, ARB, WR);
    req[0] = 1'b0;
    set_bank(1, 1'b1, 2'd1);
    set_bank(2, 1'b1, 2'd0);
    step("sc2_ctrl", 4'b0100, ARB, WR);
    req[2] = 1'b0;
    step("sc2_sw", 4'b0000, ARB, WR);
    step("sc2_t0", 4'b0000, TURN, WR);
    step("sc2_t1", 4'b0000, TURN, WR);
    step("sc2_rd", 4'b0010, ARB, RD);

    // Reset in the middle of a turnaround bubble.
    req = '0;
    do_reset("rt");
    set_bank(0, 1'b1, 2'd2);
    set_bank(1, 1'b1, 2'd1);
    for (int k = 0; k < 4; k++) step("rt_w", 4'b0001, ARB, WR);
    step("rt_sw", 4'b0000, ARB, WR);
    step("rt_t0", 4'b0000, TURN, WR);
    do_reset("rt_mid");
    step("rt_after", 4'b0001, ARB, WR);

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
